// File: rtl/cpu_step2_pkg.sv
// Shared decode-stage definitions: opcodes, ALU codes, operand-mux selects,
// instruction field positions and the control decoder function.
package cpu_step2_pkg;

  localparam int XLEN     = 16;
  localparam int REG_AW   = 3;
  localparam int RF_DEPTH = 8;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RS_MSB  = 11;
  localparam int RS_LSB  = 9;
  localparam int RT_MSB  = 8;
  localparam int RT_LSB  = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 3;
  localparam int FN_MSB  = 2;
  localparam int FN_LSB  = 0;
  localparam int IMM_W   = 6;
  localparam int ADDR_W  = 10;

  typedef enum logic [3:0] {
    OP_R    = 4'h0,
    OP_ADDI = 4'h1,
    OP_ANDI = 4'h2,
    OP_LW   = 4'h3,
    OP_SW   = 4'h4,
    OP_BEQ  = 4'h5,
    OP_BNE  = 4'h6,
    OP_J    = 4'h7,
    OP_NOP  = 4'hF
  } opcode_e;

  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_SUB = 3'd1;
  localparam logic [2:0] FN_AND = 3'd2;
  localparam logic [2:0] FN_OR  = 3'd3;
  localparam logic [2:0] FN_SLT = 3'd4;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4
  } alu_op_e;

  // SEL_RF and SEL_RT share a code: in1 reads rs, in2 reads rt from the file.
  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_RT  = 2'd0;
  localparam logic [1:0] SEL_IMM = 2'd1;
  localparam logic [1:0] SEL_ALU = 2'd2;
  localparam logic [1:0] SEL_DM  = 2'd3;

  typedef struct packed {
    alu_op_e           alu_op;
    logic              ext_imm_sign;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              branch_ne;
    logic              jump;
    logic              use_rs;
    logic              use_rt;
    logic              rt_is_in2;
    logic [REG_AW-1:0] dest;
  } ctrl_t;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [IMM_W-1:0]  imm;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   pc_next;
    logic [3:0]        alu_op;
    logic [1:0]        in1_sel;
    logic [1:0]        in2_sel;
    logic              ext_imm_sign;
    logic [REG_AW-1:0] wb_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              branch_ne;
    logic              jump;
  } idex_t;

  function automatic ctrl_t decode_instr(input logic [XLEN-1:0] instr);
    ctrl_t             c;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct;
    c      = '0;
    c.alu_op = ALU_ADD;
    rt     = instr[RT_MSB:RT_LSB];
    rd     = instr[RD_MSB:RD_LSB];
    funct  = instr[FN_MSB:FN_LSB];
    case (instr[OPC_MSB:OPC_LSB])
      OP_R: begin
        c.use_rs    = 1'b1;
        c.use_rt    = 1'b1;
        c.rt_is_in2 = 1'b1;
        c.reg_write = 1'b1;
        c.dest      = rd;
        case (funct)
          FN_ADD:  c.alu_op = ALU_ADD;
          FN_SUB:  c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_SLT:  c.alu_op = ALU_SLT;
          default: c.alu_op = ALU_ADD;
        endcase
      end
      OP_ADDI: begin
        c.use_rs       = 1'b1;
        c.ext_imm_sign = 1'b1;
        c.reg_write    = 1'b1;
        c.dest         = rt;
      end
      OP_ANDI: begin
        c.use_rs    = 1'b1;
        c.alu_op    = ALU_AND;
        c.reg_write = 1'b1;
        c.dest      = rt;
      end
      OP_LW: begin
        c.use_rs       = 1'b1;
        c.ext_imm_sign = 1'b1;
        c.mem_read     = 1'b1;
        c.reg_write    = 1'b1;
        c.dest         = rt;
      end
      OP_SW: begin
        c.use_rs       = 1'b1;
        c.use_rt       = 1'b1;
        c.ext_imm_sign = 1'b1;
        c.mem_write    = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        c.use_rs       = 1'b1;
        c.use_rt       = 1'b1;
        c.rt_is_in2    = 1'b1;
        c.ext_imm_sign = 1'b1;
        c.alu_op       = ALU_SUB;
        c.branch       = 1'b1;
        c.branch_ne    = (instr[OPC_MSB:OPC_LSB] == OP_BNE);
      end
      OP_J:    c.jump = 1'b1;
      default: c.jump = 1'b0;
    endcase
    if (c.dest == 3'd0) begin
      c.reg_write = 1'b0;
    end else begin
      c.reg_write = c.reg_write;
    end
    return c;
  endfunction

endpackage

// File: rtl/cpu_step2_regfile.sv
// 8x16 register file: r0 hard-wired to zero, two async read ports that see
// a same-cycle writeback, one synchronous write port.
module regfile8x16
  import cpu_step2_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [REG_AW-1:0] ra1_i,
  input  logic [REG_AW-1:0] ra2_i,
  output logic [XLEN-1:0]   rd1_o,
  output logic [XLEN-1:0]   rd2_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [XLEN-1:0]   wd_i
);

  logic [XLEN-1:0] mem_q [RF_DEPTH];
  logic            wr_en_s;

  assign wr_en_s = we_i && (wa_i != 3'd0);

  // storage; r0 is never written so it stays zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // read ports with writeback bypass
  always_comb begin
    rd1_o = mem_q[ra1_i];
    rd2_o = mem_q[ra2_i];
    if (wr_en_s && (wa_i == ra1_i)) begin
      rd1_o = wd_i;
    end else begin
      rd1_o = mem_q[ra1_i];
    end
    if (wr_en_s && (wa_i == ra2_i)) begin
      rd2_o = wd_i;
    end else begin
      rd2_o = mem_q[ra2_i];
    end
  end

endmodule

// File: rtl/cpu_step2.sv
// Decode stage: IF/ID register, register file, control decode, forwarding
// selects, load-use hazard and ID/EX register. Option macro: CPU_STEP2_FWD_EN.
module cpu_step2
  import cpu_step2_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [XLEN-1:0]   if_instr_i,
  input  logic [XLEN-1:0]   if_pc_next_i,
  input  logic              if_valid_i,
  input  logic              flush_i,
  input  logic              wb_reg_write_i,
  input  logic [REG_AW-1:0] wb_reg_i,
  input  logic [XLEN-1:0]   wb_data_i,
  input  logic              mem_reg_write_i,
  input  logic [REG_AW-1:0] mem_wb_reg_i,
  output logic              stall_o,
  output logic [XLEN-1:0]   ex_rd1_o,
  output logic [XLEN-1:0]   ex_rd2_o,
  output logic [IMM_W-1:0]  ex_imm_o,
  output logic [ADDR_W-1:0] ex_addr_o,
  output logic [XLEN-1:0]   ex_pc_next_o,
  output logic [3:0]        ex_alu_op_o,
  output logic [1:0]        ex_in1_sel_o,
  output logic [1:0]        ex_in2_sel_o,
  output logic              ex_ext_imm_sign_o,
  output logic [REG_AW-1:0] ex_wb_reg_o,
  output logic              ex_reg_write_o,
  output logic              ex_mem_read_o,
  output logic              ex_mem_write_o,
  output logic              ex_branch_o,
  output logic              ex_branch_ne_o,
  output logic              ex_jump_o,
  output logic              ex_valid_o
);

  logic [XLEN-1:0]   id_instr_q, id_instr_d;
  logic [XLEN-1:0]   id_pc_next_q, id_pc_next_d;
  logic              id_valid_q, id_valid_d;
  idex_t             ex_q, ex_d;

  ctrl_t             ctrl_s;
  logic [REG_AW-1:0] rs_s, rt_s;
  logic [XLEN-1:0]   rf_rd1_s, rf_rd2_s;
  logic              ex_fwd_ok_s;
  logic              rs_ex_hit_s, rs_mem_hit_s, rt_ex_hit_s, rt_mem_hit_s;
  logic              hazard_s, stall_s;
  logic [1:0]        in1_sel_s, in2_sel_s;

  assign ctrl_s = decode_instr(id_instr_q);
  assign rs_s   = id_instr_q[RS_MSB:RS_LSB];
  assign rt_s   = id_instr_q[RT_MSB:RT_LSB];

  regfile8x16 u_rf (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .ra1_i  (rs_s),
    .ra2_i  (rt_s),
    .rd1_o  (rf_rd1_s),
    .rd2_o  (rf_rd2_s),
    .we_i   (wb_reg_write_i),
    .wa_i   (wb_reg_i),
    .wd_i   (wb_data_i)
  );

  // source-vs-destination matches against EX and MEM; r0 never matches
  always_comb begin
    ex_fwd_ok_s  = ex_q.valid && ex_q.reg_write;
    rs_ex_hit_s  = ctrl_s.use_rs && (rs_s != 3'd0) && ex_fwd_ok_s && (ex_q.wb_reg == rs_s);
    rt_ex_hit_s  = ctrl_s.use_rt && (rt_s != 3'd0) && ex_fwd_ok_s && (ex_q.wb_reg == rt_s);
    rs_mem_hit_s = ctrl_s.use_rs && (rs_s != 3'd0) && mem_reg_write_i && (mem_wb_reg_i == rs_s);
    rt_mem_hit_s = ctrl_s.use_rt && (rt_s != 3'd0) && mem_reg_write_i && (mem_wb_reg_i == rt_s);
  end

`ifdef CPU_STEP2_FWD_EN
  // only a load in EX cannot be forwarded in time
  always_comb begin
    hazard_s = id_valid_q && ex_q.valid && ex_q.mem_read && (ex_q.wb_reg != 3'd0) &&
               ((ctrl_s.use_rs && (rs_s == ex_q.wb_reg)) ||
                (ctrl_s.use_rt && (rt_s == ex_q.wb_reg)));
    if (rs_ex_hit_s) begin
      in1_sel_s = SEL_ALU;
    end else if (rs_mem_hit_s) begin
      in1_sel_s = SEL_DM;
    end else begin
      in1_sel_s = SEL_RF;
    end
    if (!ctrl_s.rt_is_in2) begin
      in2_sel_s = SEL_IMM;
    end else if (rt_ex_hit_s) begin
      in2_sel_s = SEL_ALU;
    end else if (rt_mem_hit_s) begin
      in2_sel_s = SEL_DM;
    end else begin
      in2_sel_s = SEL_RT;
    end
  end
`else
  // without forwarding, wait out any producer still in EX or MEM
  always_comb begin
    hazard_s  = id_valid_q && (rs_ex_hit_s || rt_ex_hit_s || rs_mem_hit_s || rt_mem_hit_s);
    in1_sel_s = SEL_RF;
    in2_sel_s = ctrl_s.rt_is_in2 ? SEL_RT : SEL_IMM;
  end
`endif

  assign stall_s = hazard_s && !flush_i;
  assign stall_o = stall_s;

  // IF/ID next state: flush squashes, stall holds, otherwise capture fetch
  always_comb begin
    id_instr_d   = id_instr_q;
    id_pc_next_d = id_pc_next_q;
    id_valid_d   = id_valid_q;
    if (flush_i) begin
      id_valid_d = 1'b0;
    end else if (stall_s) begin
      id_valid_d = id_valid_q;
    end else begin
      id_instr_d   = if_instr_i;
      id_pc_next_d = if_pc_next_i;
      id_valid_d   = if_valid_i;
    end
  end

  // ID/EX next state: an all-zero bubble unless a valid instruction issues
  always_comb begin
    ex_d = '0;
    if (id_valid_q && !stall_s && !flush_i) begin
      ex_d.valid        = 1'b1;
      ex_d.rd1          = rf_rd1_s;
      ex_d.rd2          = rf_rd2_s;
      ex_d.imm          = id_instr_q[IMM_W-1:0];
      ex_d.addr         = id_instr_q[ADDR_W-1:0];
      ex_d.pc_next      = id_pc_next_q;
      ex_d.alu_op       = ctrl_s.alu_op;
      ex_d.in1_sel      = in1_sel_s;
      ex_d.in2_sel      = in2_sel_s;
      ex_d.ext_imm_sign = ctrl_s.ext_imm_sign;
      ex_d.wb_reg       = ctrl_s.dest;
      ex_d.reg_write    = ctrl_s.reg_write;
      ex_d.mem_read     = ctrl_s.mem_read;
      ex_d.mem_write    = ctrl_s.mem_write;
      ex_d.branch       = ctrl_s.branch;
      ex_d.branch_ne    = ctrl_s.branch_ne;
      ex_d.jump         = ctrl_s.jump;
    end else begin
      ex_d = '0;
    end
  end

  // pipeline registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_instr_q   <= '0;
      id_pc_next_q <= '0;
      id_valid_q   <= 1'b0;
      ex_q         <= '0;
    end else begin
      id_instr_q   <= id_instr_d;
      id_pc_next_q <= id_pc_next_d;
      id_valid_q   <= id_valid_d;
      ex_q         <= ex_d;
    end
  end

  assign ex_rd1_o          = ex_q.rd1;
  assign ex_rd2_o          = ex_q.rd2;
  assign ex_imm_o          = ex_q.imm;
  assign ex_addr_o         = ex_q.addr;
  assign ex_pc_next_o      = ex_q.pc_next;
  assign ex_alu_op_o       = ex_q.alu_op;
  assign ex_in1_sel_o      = ex_q.in1_sel;
  assign ex_in2_sel_o      = ex_q.in2_sel;
  assign ex_ext_imm_sign_o = ex_q.ext_imm_sign;
  assign ex_wb_reg_o       = ex_q.wb_reg;
  assign ex_reg_write_o    = ex_q.reg_write;
  assign ex_mem_read_o     = ex_q.mem_read;
  assign ex_mem_write_o    = ex_q.mem_write;
  assign ex_branch_o       = ex_q.branch;
  assign ex_branch_ne_o    = ex_q.branch_ne;
  assign ex_jump_o         = ex_q.jump;
  assign ex_valid_o        = ex_q.valid;

endmodule

// File: tb/tb_cpu_step2.sv
// Directed bench for cpu_step2; expectations follow CPU_STEP2_FWD_EN.
module tb_cpu_step2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] if_instr, if_pc_next;
  logic        if_valid, flush;
  logic        wb_reg_write;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
  logic        mem_reg_write;
  logic [2:0]  mem_wb_reg;
  logic        stall;
  logic [15:0] ex_rd1, ex_rd2, ex_pc_next;
  logic [5:0]  ex_imm;
  logic [9:0]  ex_addr;
  logic [3:0]  ex_alu_op;
  logic [1:0]  ex_in1_sel, ex_in2_sel;
  logic        ex_ext_imm_sign;
  logic [2:0]  ex_wb_reg;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_branch, ex_branch_ne, ex_jump, ex_valid;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] I_ADDI_R1 = 16'h1045; // ADDI r1,r0,5
  localparam logic [15:0] I_ADD_R2  = 16'h0250; // ADD r2,r1,r1
  localparam logic [15:0] I_LW_R3   = 16'h30C0; // LW r3,0(r0)
  localparam logic [15:0] I_ADD_R4  = 16'h0620; // ADD r4,r3,r0
  localparam logic [15:0] I_ADD_R6  = 16'h0A30; // ADD r6,r5,r0
  localparam logic [15:0] I_BEQ     = 16'h503E; // BEQ r0,r0,-2
  localparam logic [15:0] I_J       = 16'h7155; // J 0x155

  always #5 clk = ~clk;

  cpu_step2 dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .if_instr_i        (if_instr),
    .if_pc_next_i      (if_pc_next),
    .if_valid_i        (if_valid),
    .flush_i           (flush),
    .wb_reg_write_i    (wb_reg_write),
    .wb_reg_i          (wb_reg),
    .wb_data_i         (wb_data),
    .mem_reg_write_i   (mem_reg_write),
    .mem_wb_reg_i      (mem_wb_reg),
    .stall_o           (stall),
    .ex_rd1_o          (ex_rd1),
    .ex_rd2_o          (ex_rd2),
    .ex_imm_o          (ex_imm),
    .ex_addr_o         (ex_addr),
    .ex_pc_next_o      (ex_pc_next),
    .ex_alu_op_o       (ex_alu_op),
    .ex_in1_sel_o      (ex_in1_sel),
    .ex_in2_sel_o      (ex_in2_sel),
    .ex_ext_imm_sign_o (ex_ext_imm_sign),
    .ex_wb_reg_o       (ex_wb_reg),
    .ex_reg_write_o    (ex_reg_write),
    .ex_mem_read_o     (ex_mem_read),
    .ex_mem_write_o    (ex_mem_write),
    .ex_branch_o       (ex_branch),
    .ex_branch_ne_o    (ex_branch_ne),
    .ex_jump_o         (ex_jump),
    .ex_valid_o        (ex_valid)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {ex_rd1, ex_rd2, ex_imm, ex_addr, ex_pc_next, ex_alu_op, ex_in1_sel,
              ex_in2_sel, ex_ext_imm_sign, ex_wb_reg, ex_reg_write, ex_mem_read,
              ex_mem_write, ex_branch, ex_branch_ne, ex_jump, ex_valid}, 128'd0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; if_instr = 16'hF000; if_pc_next = 16'd0; if_valid = 1'b0;
    flush = 1'b0; wb_reg_write = 1'b0; wb_reg = 3'd0; wb_data = 16'd0;
    mem_reg_write = 1'b0; mem_wb_reg = 3'd0;
    #2;
    chk_all_zero("reset_ex");
    chk("reset_stall", stall, 1'b0);
    cyc(); cyc();
    rst_n = 1'b1;

    // ALU result feeding the next instruction
    if_instr = I_ADDI_R1; if_pc_next = 16'd1; if_valid = 1'b1;
    cyc();
    if_instr = I_ADD_R2; if_pc_next = 16'd2; #1;
    chk("raw_stall_ex_empty", stall, 1'b0);
    cyc();
    chk("addi_ctrl", {ex_valid, ex_reg_write, ex_wb_reg, ex_in2_sel, ex_ext_imm_sign, ex_imm, ex_pc_next},
        {1'b1, 1'b1, 3'd1, 2'd1, 1'b1, 6'd5, 16'd1});
    if_valid = 1'b0; #1;
`ifdef CPU_STEP2_FWD_EN
    chk("raw_no_stall", stall, 1'b0);
    cyc();
    chk("raw_fwd_alu", {ex_valid, ex_in1_sel, ex_in2_sel, ex_wb_reg, ex_rd1}, {1'b1, 2'd2, 2'd2, 3'd2, 16'd0});
`else
    chk("raw_stall_ex", stall, 1'b1);
    cyc();
    chk("raw_bubble1", ex_valid, 1'b0);
    mem_reg_write = 1'b1; mem_wb_reg = 3'd1; #1;
    chk("raw_stall_mem", stall, 1'b1);
    cyc();
    chk("raw_bubble2", ex_valid, 1'b0);
    mem_reg_write = 1'b0; #1;
    chk("raw_stall_clear", stall, 1'b0);
    cyc();
    chk("raw_issue_rf", {ex_valid, ex_in1_sel, ex_in2_sel, ex_wb_reg, ex_rd1}, {1'b1, 2'd0, 2'd0, 3'd2, 16'd0});
`endif
    mem_reg_write = 1'b0;
    cyc();
    chk("invalid_bubble", {ex_valid, ex_reg_write}, 2'b00);

    // load followed by a dependent ALU op
    if_instr = I_LW_R3; if_pc_next = 16'd3; if_valid = 1'b1;
    cyc();
    if_instr = I_ADD_R4; if_pc_next = 16'd4;
    cyc();
    chk("lw_ctrl", {ex_valid, ex_mem_read, ex_reg_write, ex_wb_reg, ex_in1_sel}, {1'b1, 1'b1, 1'b1, 3'd3, 2'd0});
    if_valid = 1'b0; #1;
    chk("loaduse_stall", stall, 1'b1);
    cyc();
    chk("loaduse_bubble", {ex_valid, ex_mem_read, ex_reg_write}, 3'b000);
    mem_reg_write = 1'b1; mem_wb_reg = 3'd3; #1;
`ifdef CPU_STEP2_FWD_EN
    chk("loaduse_release", stall, 1'b0);
    cyc();
    chk("loaduse_fwd_dm", {ex_valid, ex_in1_sel, ex_in2_sel, ex_wb_reg}, {1'b1, 2'd3, 2'd0, 3'd4});
`else
    chk("loaduse_stall_mem", stall, 1'b1);
    cyc();
    chk("loaduse_bubble2", ex_valid, 1'b0);
    mem_reg_write = 1'b0; #1;
    chk("loaduse_release", stall, 1'b0);
    cyc();
    chk("loaduse_issue_rf", {ex_valid, ex_in1_sel, ex_in2_sel, ex_wb_reg}, {1'b1, 2'd0, 2'd0, 3'd4});
`endif
    mem_reg_write = 1'b0;
    cyc();

    // flush arriving while the load-use stall is active
    if_instr = I_LW_R3; if_pc_next = 16'd3; if_valid = 1'b1;
    cyc();
    if_instr = I_ADD_R4; if_pc_next = 16'd4;
    cyc();
    if_valid = 1'b0; flush = 1'b1; #1;
    chk("flush_kills_stall", stall, 1'b0);
    cyc();
    chk("flush_bubble", ex_valid, 1'b0);
    flush = 1'b0; #1;
    chk("flush_no_stall", stall, 1'b0);
    cyc();
    chk("flush_squashed", {ex_valid, ex_reg_write}, 2'b00);

    // writeback bypass and write to r0
    if_instr = I_ADD_R6; if_pc_next = 16'd6; if_valid = 1'b1;
    cyc();
    wb_reg_write = 1'b1; wb_reg = 3'd5; wb_data = 16'hBEEF;
    cyc();
    chk("wb_bypass", {ex_valid, ex_rd1, ex_rd2, ex_wb_reg}, {1'b1, 16'hBEEF, 16'h0000, 3'd6});
    wb_reg = 3'd0; wb_data = 16'h1234; if_valid = 1'b0;
    cyc();
    chk("wb_r0_ignored", {ex_valid, ex_rd1, ex_rd2}, {1'b1, 16'hBEEF, 16'h0000});
    wb_reg_write = 1'b0;
    cyc();

    // branch and jump field decode
    if_instr = I_BEQ; if_pc_next = 16'd7; if_valid = 1'b1;
    cyc();
    if_instr = I_J; if_pc_next = 16'd8;
    cyc();
    chk("beq_ctrl", {ex_valid, ex_branch, ex_branch_ne, ex_ext_imm_sign, ex_imm, ex_reg_write, ex_alu_op, ex_in2_sel, ex_pc_next},
        {1'b1, 1'b1, 1'b0, 1'b1, 6'h3E, 1'b0, 4'd1, 2'd0, 16'd7});
    if_valid = 1'b0;
    cyc();
    chk("j_ctrl", {ex_valid, ex_jump, ex_addr, ex_branch, ex_reg_write}, {1'b1, 1'b1, 10'h155, 1'b0, 1'b0});
    cyc();

    // reset asserted in the middle of a stall
    if_instr = I_LW_R3; if_pc_next = 16'd3; if_valid = 1'b1;
    cyc();
    if_instr = I_ADD_R4; if_pc_next = 16'd4;
    cyc();
    if_valid = 1'b0; #1;
    chk("pre_reset_stall", stall, 1'b1);
    rst_n = 1'b0; #1;
    chk("midstall_reset_stall", stall, 1'b0);
    chk_all_zero("midstall_reset_ex");
    cyc();
    rst_n = 1'b1;
    if_instr = I_ADD_R6; if_pc_next = 16'd9; if_valid = 1'b1;
    cyc();
    if_valid = 1'b0;
    cyc();
    chk("rf_cleared_by_reset", {ex_valid, ex_rd1, ex_pc_next}, {1'b1, 16'h0000, 16'd9});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
